sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WORD_WIDTH, default 256: data width of the single-port SRAM word.
REQ-002 Parameter ADDR_WIDTH, default 10: SRAM address width.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 a_req, a_we, a_lock  input  1 each  requester A (PE write-back): request, write-enable, hold-grant.
REQ-006 a_addr  input  ADDR_WIDTH; a_wdata  input  WORD_WIDTH  requester A address/data.
REQ-007 a_gnt  output  1; a_rvalid  output  1; a_rdata  output  WORD_WIDTH  requester A grant, read-return strobe, read data.
REQ-008 b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same directions/widths as A  requester B (host readout).
REQ-009 sram_cen, sram_wen  output  1 each  SRAM chip enable, write enable, both active-low.
REQ-010 sram_addr  output  ADDR_WIDTH; sram_din  output  WORD_WIDTH; sram_q  input  WORD_WIDTH  SRAM address, write data, registered read data.

Function
REQ-011 Transaction accepted in cycle when x_req & x_gnt; grants are combinational from current req and state; at most one grant per cycle.
REQ-012 Accepted access drives sram_cen=0, sram_wen=~x_we, sram_addr=x_addr, sram_din=x_wdata in the same cycle; no acceptance: sram_cen=1, sram_wen=1, addr/din=0.
REQ-013 Read latency exactly 1 cycle: x_rvalid=1 in cycle after an accepted read by x, x_rdata=sram_q then; otherwise x_rdata=0.
REQ-014 Writes produce no rvalid; back-to-back accesses every cycle supported.
REQ-015 FSM states IDLE, LOCK_A, LOCK_B.
REQ-016 IDLE: single requester wins; both requesting resolved by arbitration policy (REQ-024/025).
REQ-017 IDLE -> LOCK_x when x accepted with x_lock=1.
REQ-018 LOCK_x: only x may be granted, other requester held off regardless of policy; gnt asserted when x_req.
REQ-019 LOCK_x -> IDLE in cycle after a cycle where x_lock=0 (x_req irrelevant); that cycle is still granted to x if x_req.
REQ-020 Last-grant pointer updates on every acceptance to the accepted requester.
REQ-021 Out-of-range address passed through unchanged; SRAM returns 0, rvalid still asserted.

Reset
REQ-022 rst_n=0: state=IDLE, pointer=B (A wins first tie), pending read tag cleared; a_gnt/b_gnt/rvalids=0, sram_cen=1, sram_wen=1, all data outputs 0.
REQ-023 Reset mid-read: accepted read in flight is dropped, no rvalid after reset release; lock released.

Configuration
REQ-024 Macro SRAM_ARB_RR_EN defined: IDLE ties go to requester not in last-grant pointer (round-robin).
REQ-025 SRAM_ARB_RR_EN undefined: IDLE ties always go to A (fixed priority); pointer register still present, unused for tie-break; lock behaviour identical.

Verification
REQ-026 After reset, a_req=b_req=1 reads addr 5/6, no lock -> RR build: gnt A,B,A,B alternating; fixed build: A every cycle, b_gnt=0.
REQ-027 A writes 0xABCD to addr 3, next cycle B reads addr 3 -> b_rvalid=1 two cycles after write, b_rdata=0xABCD, a_rvalid stays 0.
REQ-028 A accepted with a_lock=1 for 4 cycles, b_req=1 throughout -> b_gnt=0 those 4 cycles plus zero extra; B granted cycle after a_lock falls.
REQ-029 B read addr 1024 with ADDR_WIDTH=11 (depth 1024 SRAM model) -> b_rvalid=1, b_rdata=0.
REQ-030 rst_n pulsed low in cycle after accepted A read -> a_rvalid=0, state IDLE, sram_cen=1 during and after reset until next request.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester arbiter in front of a single-port SRAM.
//   Requester A (PE write-back) and requester B (host readout) compete for the
//   SRAM. Grants are combinational and an accepted access reaches the SRAM in
//   the same cycle. Read data returns to the requester one cycle later.
//   A requester can hold the SRAM across cycles with its lock input.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   {a,b}_req/_we/_lock/_addr/_wdata  requester request, write enable,
//                                   hold-grant, address, write data
//   {a,b}_gnt/_rvalid/_rdata        grant, read-return strobe, read data
//   sram_cen/_wen/_addr/_din/_q     SRAM port (cen/wen active-low)
// Configuration macro:
//   SRAM_ARB_RR_EN  defined   -> IDLE ties alternate (round-robin)
//                   undefined -> IDLE ties always go to A (fixed priority)
// Latency: grant and SRAM drive in the same cycle, read data 1 cycle later.
// Backpressure: a requester whose req is not granted simply holds req high.

module sram_arbiter #(
  parameter int WORD_WIDTH = 256,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WORD_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [WORD_WIDTH-1:0] a_rdata,

  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [WORD_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [WORD_WIDTH-1:0] b_rdata,

  output logic                  sram_cen,
  output logic                  sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WORD_WIDTH-1:0] sram_din,
  input  logic [WORD_WIDTH-1:0] sram_q
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t state;

  // Last-grant pointer: 1 means B was granted most recently. Resets to B so
  // that A wins the first tie.
  logic last_b;

  // Pending read tags: an accepted read from A/B is returning next cycle.
  logic rd_a;
  logic rd_b;

  logic a_win;
  logic b_win;
  logic a_acc;
  logic b_acc;

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    case (state)
      LOCK_A: a_win = a_req;
      LOCK_B: b_win = b_req;
      default: begin
        if (a_req && b_req) begin
`ifdef SRAM_ARB_RR_EN
          // Tie goes to whoever was not granted last.
          a_win = last_b;
          b_win = ~last_b;
`else
          a_win = 1'b1;
          b_win = 1'b0;
`endif
        end else begin
          a_win = a_req;
          b_win = b_req;
        end
      end
    endcase
  end

  // Grants are forced low while reset is asserted, even if requests are held.
  assign a_gnt = a_win & rst_n;
  assign b_gnt = b_win & rst_n;

  // A grant is only raised together with its request, so grant == accept.
  assign a_acc = a_req & a_gnt;
  assign b_acc = b_req & b_gnt;

  // ---------------------------------------------------------------------------
  // SRAM drive: idle port parks at cen=1, wen=1, zero address/data.
  // ---------------------------------------------------------------------------
  always_comb begin
    sram_cen  = 1'b1;
    sram_wen  = 1'b1;
    sram_addr = '0;
    sram_din  = '0;
    if (a_acc) begin
      sram_cen  = 1'b0;
      sram_wen  = ~a_we;
      sram_addr = a_addr;
      sram_din  = a_wdata;
    end else if (b_acc) begin
      sram_cen  = 1'b0;
      sram_wen  = ~b_we;
      sram_addr = b_addr;
      sram_din  = b_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // State, pointer and read-return tags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_b <= 1'b1;
      rd_a   <= 1'b0;
      rd_b   <= 1'b0;
    end else begin
      // Pointer follows every acceptance and otherwise holds.
      last_b <= b_acc | (last_b & ~a_acc);

      // Read tags: one-cycle delayed copy of "accepted read".
      rd_a <= a_acc & ~a_we;
      rd_b <= b_acc & ~b_we;

      case (state)
        IDLE: begin
          if (a_acc && a_lock) begin
            state <= LOCK_A;
          end else if (b_acc && b_lock) begin
            state <= LOCK_B;
          end
        end
        // Leaving a lock depends only on the owner's lock bit; the cycle in
        // which lock drops is still owned (and granted if the owner requests).
        LOCK_A: begin
          if (!a_lock) begin
            state <= IDLE;
          end
        end
        LOCK_B: begin
          if (!b_lock) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: SRAM output is steered to whoever issued the read and is
  // zero for the other requester and when no read is returning.
  // ---------------------------------------------------------------------------
  assign a_rvalid = rd_a;
  assign b_rvalid = rd_b;
  assign a_rdata  = rd_a ? sram_q : '0;
  assign b_rdata  = rd_b ? sram_q : '0;

endmodule
